mem_port_arbiter: RTL

- Shares one single-ported unified memory between the core's instruction-fetch interface and its data load/store interface.
- Captures single-cycle request pulses from each side into a one-entry pending buffer per requester.
- Issues at most one memory access per cycle and routes read data back to the requester that issued it.
- Sits between the core and the memory macro. The core keeps its split instruction/data view of memory.

---
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between i-fetch and d load/store; define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          err_ovf
);
  typedef enum logic [1:0] {IDLE, ISSUE_I, ISSUE_D} state_t;
  state_t state, state_n;
  logic pend_i, pend_d, pd_we;
  logic [AW-1:0] pi_addr, pd_addr;
  logic [DW-1:0] pd_wdata;
  logic cand_i, cand_d, d_wins, gnt_i, gnt_d, ovf;
  logic [READ_LATENCY-1:0] tv, to;
  // an empty buffer lets a fresh request bypass straight into arbitration
  assign cand_i = pend_i | i_req;
  assign cand_d = pend_d | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;
  assign d_wins = cand_d & (~cand_i | ~last_d);
  always_ff @(posedge clk)
    if (rst) last_d <= 1'b0;
    else if (gnt_d | gnt_i) last_d <= gnt_d;
`else
  assign d_wins = cand_d;
`endif
  always_comb begin
    state_n = d_wins ? ISSUE_D : cand_i ? ISSUE_I : IDLE;
  end
  assign gnt_i = state_n == ISSUE_I;
  assign gnt_d = state_n == ISSUE_D;
  assign ovf = (i_req & pend_i & ~gnt_i) | (d_req & pend_d & ~gnt_d);
  assign m_en = state != IDLE;
  assign busy = pend_i | pend_d | m_en | (|tv) | i_rvalid | d_rvalid;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_i <= 1'b0;
      pend_d <= 1'b0;
      pi_addr <= '0;
      pd_addr <= '0;
      pd_we <= 1'b0;
      pd_wdata <= '0;
      m_we <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      err_ovf <= 1'b0;
    end else begin
      state <= state_n;
      m_we <= gnt_d & (pend_d ? pd_we : d_we);
      m_addr <= gnt_d ? (pend_d ? pd_addr : d_addr) : gnt_i ? (pend_i ? pi_addr : i_addr) : '0;
      m_wdata <= gnt_d ? (pend_d ? pd_wdata : d_wdata) : '0;
      err_ovf <= err_ovf | ovf;
      pend_i <= (pend_i & ~gnt_i) | (i_req & (pend_i ? gnt_i : ~gnt_i));
      pend_d <= (pend_d & ~gnt_d) | (d_req & (pend_d ? gnt_d : ~gnt_d));
      if (i_req & (pend_i ? gnt_i : ~gnt_i)) pi_addr <= i_addr;
      if (d_req & (pend_d ? gnt_d : ~gnt_d)) begin
        pd_addr <= d_addr;
        pd_we <= d_we;
        pd_wdata <= d_wdata;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tv <= '0;
      to <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      for (int k = READ_LATENCY - 1; k > 0; k--) begin
        tv[k] <= tv[k-1];
        to[k] <= to[k-1];
      end
      tv[0] <= m_en & ~m_we;
      to[0] <= state == ISSUE_D;
      i_rvalid <= tv[READ_LATENCY-1] & ~to[READ_LATENCY-1];
      d_rvalid <= tv[READ_LATENCY-1] & to[READ_LATENCY-1];
      if (tv[READ_LATENCY-1] & ~to[READ_LATENCY-1]) i_rdata <= m_rdata;
      if (tv[READ_LATENCY-1] & to[READ_LATENCY-1]) d_rdata <= m_rdata;
    end
  end
endmodule
